// File: rtl/pwm_pair_mon.sv
// rtl/pwm_pair_mon.sv - PWM high/low pair monitor: duty, overlap and period checks
// One window runs from a PWM_synch rising edge to the cycle before the next one.
module pwm_pair_mon #(
  parameter int NCH        = 2,
  parameter int PER_W      = 11,
  parameter int NONOVERLAP = 32,
  parameter int TOL        = 4
) (
  input  logic                     clk,
  input  logic                     RST_n,
  input  logic                     en,
  input  logic                     PWM_synch,
  input  logic [NCH-1:0]           PWM1,
  input  logic [NCH-1:0]           PWM2,
  input  logic [NCH*PER_W-1:0]     duty,
  input  logic                     clr_err,
  output logic                     meas_vld,
  output logic [NCH*(PER_W+1)-1:0] hi1_cnt,
  output logic [NCH*(PER_W+1)-1:0] hi2_cnt,
  output logic [NCH-1:0]           err_duty1,
  output logic [NCH-1:0]           err_duty2,
  output logic [NCH-1:0]           err_ovlp,
  output logic                     err_synch
);

  localparam int CW = PER_W + 1;
  localparam int EW = PER_W + 2;
  localparam logic [CW-1:0]        P_MIN = CW'((1 << PER_W) - TOL);
  localparam logic [CW-1:0]        P_MAX = CW'((1 << PER_W) + TOL);
  localparam logic signed [EW-1:0] PER_S = EW'(1 << PER_W);
  localparam logic signed [EW-1:0] NOV_S = EW'(NONOVERLAP);
  localparam logic signed [EW-1:0] TOL_S = EW'(TOL);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  state_t state_q, state_d;

  logic                      synch_q, synch_edge;
  logic                      open_win, close_ok, close_short, timeout, watch;
  logic [CW-1:0]             per_q, per_d;
  logic [NCH-1:0][CW-1:0]    c1_q, c1_d, c2_q, c2_d;
  logic [NCH-1:0][CW-1:0]    hi1_q, hi1_d, hi2_q, hi2_d;
  logic [NCH-1:0][PER_W-1:0] duty_q, duty_d;
  logic [NCH-1:0]            bad1, bad2;
  logic [NCH-1:0]            ed1_q, ed1_d, ed2_q, ed2_d, ov_q, ov_d;
  logic                      es_q, es_d, vld_q, vld_d;

  assign synch_edge = PWM_synch & ~synch_q;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (synch_edge) state_d = MEAS;
        MEAS:    if (!synch_edge && per_q >= P_MAX) state_d = ARM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    open_win    = 1'b0;
    close_ok    = 1'b0;
    close_short = 1'b0;
    timeout     = 1'b0;
    watch       = (state_q == ARM) || (state_q == MEAS);
    if (en) begin
      case (state_q)
        ARM:  open_win = synch_edge;
        MEAS: begin
          if (synch_edge) begin
            open_win    = 1'b1;
            close_ok    = (per_q >= P_MIN);
            close_short = (per_q < P_MIN);
          end else begin
            timeout = (per_q >= P_MAX);
          end
        end
        default: ;
      endcase
    end
  end

  // The closing edge is also cycle 0 of the next window, so it seeds the counters.
  always_comb begin
    per_d  = '0;
    c1_d   = '0;
    c2_d   = '0;
    duty_d = duty_q;
    if (open_win) begin
      per_d  = CW'(1);
      duty_d = duty;
      for (int k = 0; k < NCH; k++) begin
        c1_d[k] = CW'(PWM1[k]);
        c2_d[k] = CW'(PWM2[k]);
      end
    end else if (en && state_q == MEAS && !timeout) begin
      per_d = per_q + CW'(1);
      for (int k = 0; k < NCH; k++) begin
        c1_d[k] = c1_q[k] + CW'(PWM1[k]);
        c2_d[k] = c2_q[k] + CW'(PWM2[k]);
      end
    end
  end

  always_comb begin
    logic signed [EW-1:0] dk, e1, e2, d1, d2;
    dk   = '0;
    e1   = '0;
    e2   = '0;
    d1   = '0;
    d2   = '0;
    bad1 = '0;
    bad2 = '0;
    for (int k = 0; k < NCH; k++) begin
      dk = signed'({2'b00, duty_q[k]});
      e1 = dk - NOV_S;
      if (e1 < 0) e1 = '0;
      e2 = PER_S - dk - NOV_S;
      if (e2 < 0) e2 = '0;
      d1 = signed'({1'b0, c1_q[k]}) - e1;
      if (d1 < 0) d1 = -d1;
      d2 = signed'({1'b0, c2_q[k]}) - e2;
      if (d2 < 0) d2 = -d2;
      bad1[k] = (d1 > TOL_S);
      bad2[k] = (d2 > TOL_S);
    end
  end

  // Sticky flags: a new set in the clearing cycle survives the clear.
  assign ed1_d = (ed1_q & ~{NCH{clr_err}}) | (close_ok ? bad1 : '0);
  assign ed2_d = (ed2_q & ~{NCH{clr_err}}) | (close_ok ? bad2 : '0);
  assign ov_d  = (ov_q & ~{NCH{clr_err}}) | (watch ? (PWM1 & PWM2) : '0);
  assign es_d  = (es_q & ~clr_err) | close_short | timeout;
  assign vld_d = close_ok;
  assign hi1_d = close_ok ? c1_q : hi1_q;
  assign hi2_d = close_ok ? c2_q : hi2_q;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      synch_q <= 1'b0;
      per_q   <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      hi1_q   <= '0;
      hi2_q   <= '0;
      duty_q  <= '0;
      ed1_q   <= '0;
      ed2_q   <= '0;
      ov_q    <= '0;
      es_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      synch_q <= PWM_synch;
      per_q   <= per_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      hi1_q   <= hi1_d;
      hi2_q   <= hi2_d;
      duty_q  <= duty_d;
      ed1_q   <= ed1_d;
      ed2_q   <= ed2_d;
      ov_q    <= ov_d;
      es_q    <= es_d;
      vld_q   <= vld_d;
    end
  end

  assign meas_vld  = vld_q;
  assign hi1_cnt   = hi1_q;
  assign hi2_cnt   = hi2_q;
  assign err_duty1 = ed1_q;
  assign err_duty2 = ed2_q;
  assign err_ovlp  = ov_q;
  assign err_synch = es_q;

endmodule

// File: tb/tb_pwm_pair_mon.sv
// tb/tb_pwm_pair_mon.sv - self-checking bench for pwm_pair_mon
`timescale 1ns/1ps
module tb_pwm_pair_mon;
  localparam int NCH = 2, PER_W = 11, NOV = 32, TOL = 4, CW = 12, PER = 2048;

  logic                 clk = 1'b0;
  logic                 rst_n, en, synch, clr;
  logic [NCH-1:0]       pwm1, pwm2;
  logic [NCH*PER_W-1:0] duty;
  logic                 meas_vld, err_synch;
  logic [NCH*CW-1:0]    hi1_cnt, hi2_cnt;
  logic [NCH-1:0]       err_duty1, err_duty2, err_ovlp;

  always #5 clk = ~clk;

  pwm_pair_mon #(.NCH(NCH), .PER_W(PER_W), .NONOVERLAP(NOV), .TOL(TOL)) dut (
    .clk(clk), .RST_n(rst_n), .en(en), .PWM_synch(synch), .PWM1(pwm1), .PWM2(pwm2),
    .duty(duty), .clr_err(clr), .meas_vld(meas_vld), .hi1_cnt(hi1_cnt), .hi2_cnt(hi2_cnt),
    .err_duty1(err_duty1), .err_duty2(err_duty2), .err_ovlp(err_ovlp), .err_synch(err_synch)
  );

  typedef struct {
    logic [NCH*CW-1:0] hi1;
    logic [NCH*CW-1:0] hi2;
    logic [NCH-1:0]    ed1;
    logic [NCH-1:0]    ed2;
  } exp_t;

  exp_t           sb[$];
  exp_t           mon_e;
  int             total = 0;
  int             bad = 0;
  int             w_duty[NCH], w_h1[NCH], w_h2[NCH], w_s2[NCH], w_ovlp[NCH];
  int             w_clr_t;
  logic [NCH-1:0] m_ed1 = '0, m_ed2 = '0, m_ovlp = '0;

  always @(negedge clk) begin
    if (meas_vld === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL meas_vld_unexpected got=1 exp=0 t=%0t", $time);
      end else begin
        mon_e = sb.pop_front();
        if (hi1_cnt !== mon_e.hi1) begin
          bad++; $display("FAIL hi1_cnt got=%h exp=%h t=%0t", hi1_cnt, mon_e.hi1, $time);
        end
        total++;
        if (hi2_cnt !== mon_e.hi2) begin
          bad++; $display("FAIL hi2_cnt got=%h exp=%h t=%0t", hi2_cnt, mon_e.hi2, $time);
        end
        total++;
        if (err_duty1 !== mon_e.ed1) begin
          bad++; $display("FAIL err_duty1 got=%b exp=%b t=%0t", err_duty1, mon_e.ed1, $time);
        end
        total++;
        if (err_duty2 !== mon_e.ed2) begin
          bad++; $display("FAIL err_duty2 got=%b exp=%b t=%0t", err_duty2, mon_e.ed2, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    for (int k = 0; k < NCH; k++) begin
      w_duty[k] = 1024; w_h1[k] = 992; w_h2[k] = 992; w_s2[k] = -1; w_ovlp[k] = -1;
    end
    w_clr_t = -1;
  endtask

  task automatic clear_model();
    m_ed1 = '0; m_ed2 = '0; m_ovlp = '0;
  endtask

  // PWM1 high from cycle 16; PWM2 follows after the dead time unless w_s2 overrides.
  task automatic drive_window(input int len, input bit push);
    int             c1[NCH];
    int             c2[NCH];
    int             s2, e1, e2;
    logic [NCH-1:0] p1, p2, ov;
    exp_t           e;
    for (int k = 0; k < NCH; k++) begin c1[k] = 0; c2[k] = 0; end
    for (int t = 0; t < len; t++) begin
      for (int k = 0; k < NCH; k++) begin
        s2 = (w_s2[k] >= 0) ? w_s2[k] : 16 + w_h1[k] + NOV;
        p1[k] = (t >= 16) && (t < 16 + w_h1[k]);
        p2[k] = ((t >= s2) && (t < s2 + w_h2[k])) || (t == w_ovlp[k]);
        c1[k] += int'(p1[k]);
        c2[k] += int'(p2[k]);
        duty[k*PER_W +: PER_W] = PER_W'(w_duty[k]);
      end
      ov    = p1 & p2;
      synch = (t == 0);
      pwm1  = p1;
      pwm2  = p2;
      clr   = (t == w_clr_t);
      if (clr) clear_model();
      m_ovlp = m_ovlp | ov;
      step();
      if (ov != '0 || t == w_clr_t) begin
        total++;
        if (err_ovlp !== m_ovlp) begin
          bad++; $display("FAIL ovlp_flag got=%b exp=%b cyc=%0d", err_ovlp, m_ovlp, t);
        end
      end
    end
    clr = 1'b0;
    if (push) begin
      for (int k = 0; k < NCH; k++) begin
        e1 = w_duty[k] - NOV;       if (e1 < 0) e1 = 0;
        e2 = PER - w_duty[k] - NOV; if (e2 < 0) e2 = 0;
        if (c1[k] - e1 > TOL || e1 - c1[k] > TOL) m_ed1[k] = 1'b1;
        if (c2[k] - e2 > TOL || e2 - c2[k] > TOL) m_ed2[k] = 1'b1;
        e.hi1[k*CW +: CW] = CW'(c1[k]);
        e.hi2[k*CW +: CW] = CW'(c2[k]);
      end
      e.ed1 = m_ed1;
      e.ed2 = m_ed2;
      sb.push_back(e);
    end
  endtask

  // Closing edge, then drop en so the freshly opened window is discarded.
  task automatic close_and_stop();
    synch = 1'b1; pwm1 = '0; pwm2 = '0;
    step();
    en = 1'b0; synch = 1'b0;
    step();
    step();
    en = 1'b1;
    step();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; synch = 1'b0; clr = 1'b0; pwm1 = '0; pwm2 = '0; duty = '0;
    repeat (3) step();
    total++; if (meas_vld !== 1'b0)  begin bad++; $display("FAIL rst_vld got=%b exp=0", meas_vld); end
    total++; if (hi1_cnt !== '0)     begin bad++; $display("FAIL rst_hi1 got=%h exp=0", hi1_cnt); end
    total++; if (hi2_cnt !== '0)     begin bad++; $display("FAIL rst_hi2 got=%h exp=0", hi2_cnt); end
    total++; if (err_duty1 !== '0)   begin bad++; $display("FAIL rst_ed1 got=%b exp=0", err_duty1); end
    total++; if (err_duty2 !== '0)   begin bad++; $display("FAIL rst_ed2 got=%b exp=0", err_duty2); end
    total++; if (err_ovlp !== '0)    begin bad++; $display("FAIL rst_ovlp got=%b exp=0", err_ovlp); end
    total++; if (err_synch !== 1'b0) begin bad++; $display("FAIL rst_synch got=%b exp=0", err_synch); end
    synch = 1'b1; en = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    synch = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_basic();
    set_defaults();
    repeat (3) drive_window(PER, 1'b1);
    close_and_stop();
    total++; if (err_synch !== 1'b0) begin bad++; $display("FAIL basic_synch got=%b exp=0", err_synch); end
    total++; if (err_ovlp !== '0)    begin bad++; $display("FAIL basic_ovlp got=%b exp=0", err_ovlp); end
  endtask

  task automatic test_sat();
    set_defaults();
    w_duty[0] = 16; w_h1[0] = 0; w_s2[0] = 20; w_h2[0] = 2010;
    drive_window(PER, 1'b1);
    close_and_stop();
    total++; if (err_duty2 !== 2'b01) begin bad++; $display("FAIL sat_ed2 got=%b exp=01", err_duty2); end
    total++; if (err_duty1 !== 2'b00) begin bad++; $display("FAIL sat_ed1 got=%b exp=00", err_duty1); end
    pulse_clr();
    total++; if (err_duty2 !== 2'b00) begin bad++; $display("FAIL sat_clr got=%b exp=00", err_duty2); end
  endtask

  task automatic test_tol();
    set_defaults();
    w_h1[0] = 996; w_h1[1] = 997;
    drive_window(PER, 1'b1);
    close_and_stop();
    total++; if (err_duty1 !== 2'b10) begin bad++; $display("FAIL tol_ed1 got=%b exp=10", err_duty1); end
    pulse_clr();
  endtask

  task automatic test_ovlp();
    set_defaults();
    w_ovlp[1] = 500;
    drive_window(PER, 1'b1);
    w_clr_t = 500;
    drive_window(PER, 1'b1);
    close_and_stop();
    pulse_clr();
    total++; if (err_ovlp !== 2'b00) begin bad++; $display("FAIL ovlp_clr got=%b exp=00", err_ovlp); end
  endtask

  task automatic test_synch();
    set_defaults();
    drive_window(1000, 1'b0);
    synch = 1'b1; pwm1 = '0; pwm2 = '0;
    step();
    total++; if (err_synch !== 1'b1) begin bad++; $display("FAIL synch_short got=%b exp=1", err_synch); end
    synch = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    total++; if (err_synch !== 1'b0) begin bad++; $display("FAIL synch_clr got=%b exp=0", err_synch); end
    repeat (2050) step();
    total++; if (err_synch !== 1'b0) begin bad++; $display("FAIL synch_early got=%b exp=0", err_synch); end
    step();
    total++; if (err_synch !== 1'b1) begin bad++; $display("FAIL synch_timeout got=%b exp=1", err_synch); end
    drive_window(PER, 1'b1);
    close_and_stop();
    pulse_clr();
    total++; if (err_synch !== 1'b0) begin bad++; $display("FAIL synch_final got=%b exp=0", err_synch); end
  endtask

  task automatic test_abort();
    set_defaults();
    drive_window(1000, 1'b0);
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    step();
    drive_window(PER, 1'b1);
    close_and_stop();
    w_ovlp[0] = 300;
    drive_window(700, 1'b0);
    w_ovlp[0] = -1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (hi1_cnt !== '0)   begin bad++; $display("FAIL abort_hi1 got=%h exp=0", hi1_cnt); end
    total++; if (hi2_cnt !== '0)   begin bad++; $display("FAIL abort_hi2 got=%h exp=0", hi2_cnt); end
    total++; if (err_ovlp !== '0)  begin bad++; $display("FAIL abort_ovlp got=%b exp=0", err_ovlp); end
    total++; if (meas_vld !== 1'b0) begin bad++; $display("FAIL abort_vld got=%b exp=0", meas_vld); end
    clear_model();
    synch = 1'b0; pwm1 = '0; pwm2 = '0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    drive_window(PER, 1'b1);
    close_and_stop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_tol();
    test_ovlp();
    test_synch();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_pair_mon.md
PWM_PAIR_MON -- requirements
Module: pwm_pair_mon

Interface
REQ-001 Parameter NCH, default 2: number of monitored PWM pair channels.
REQ-002 Parameter PER_W, default 11: PWM period is 2^PER_W clk cycles.
REQ-003 Parameter NONOVERLAP, default 32: dead time in clk cycles, applied on each edge of a pair.
REQ-004 Parameter TOL, default 4: allowed absolute error in clk cycles on every measured count.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 RST_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  monitor enable; 0 forces IDLE.
REQ-008 PWM_synch  input  1  period-start marker; a rising edge opens a window.
REQ-009 PWM1  input  NCH  high-side PWM per channel.
REQ-010 PWM2  input  NCH  low-side PWM per channel.
REQ-011 duty  input  NCH*PER_W  commanded duty per channel; channel k occupies bits [k*PER_W +: PER_W].
REQ-012 clr_err  input  1  synchronous clear of all sticky error flags.
REQ-013 meas_vld  output  1  one-cycle pulse when a completed window's results are valid.
REQ-014 hi1_cnt, hi2_cnt  output  NCH*(PER_W+1) each  measured high counts of the last valid window.
REQ-015 err_duty1, err_duty2  output  NCH each  sticky: PWM1 or PWM2 high time out of tolerance.
REQ-016 err_ovlp  output  NCH  sticky: PWM1 and PWM2 high in the same cycle.
REQ-017 err_synch  output  1  sticky: PWM_synch period out of tolerance or missing.

Function
REQ-018 Inputs are synchronous to clk; the block SHALL NOT add synchronizers.
REQ-019 Edge detect: synch_edge = PWM_synch & ~registered PWM_synch.
REQ-020 States: IDLE, ARM, MEAS.
REQ-021 IDLE->ARM when en=1; any state->IDLE when en=0, with the open window discarded and no meas_vld pulse.
REQ-022 ARM->MEAS on synch_edge; that cycle is cycle 0 of the window; duty for all channels is latched in that cycle.
REQ-023 In MEAS, the window covers synch_edge cycle through the cycle before the next synch_edge; per channel, count cycles with PWM1=1 and cycles with PWM2=1; period counter is PER_W+1 bits.
REQ-024 On a closing synch_edge with period count within 2^PER_W +/- TOL: register counts to hi1_cnt/hi2_cnt, evaluate errors, pulse meas_vld on the next cycle, and open a new window in the same cycle (no dead cycle).
REQ-025 Expected counts: exp1 = duty - NONOVERLAP, saturating at 0; exp2 = 2^PER_W - duty - NONOVERLAP, saturating at 0; compute at PER_W+2 bits signed.
REQ-026 err_duty1[k] is set when |hi1 - exp1| > TOL; err_duty2[k] is set when |hi2 - exp2| > TOL; the bound is inclusive, so a difference of exactly TOL passes.
REQ-027 Closing synch_edge with period count < 2^PER_W - TOL: set err_synch; drop counts with no meas_vld and no duty checks; open a new window.
REQ-028 Period count reaching 2^PER_W + TOL without synch_edge: set err_synch, drop counts, go to ARM.
REQ-029 err_ovlp[k] is set in the cycle after any cycle with PWM1[k]&PWM2[k]=1 in ARM or MEAS, independent of the window result.
REQ-030 Sticky errors clear only on clr_err; when a set and clr_err coincide, set wins.
REQ-031 Error evaluation is per channel; a fault on one channel SHALL NOT set flags on another.

Reset
REQ-032 RST_n low asynchronously forces IDLE; clears all counters, hi1_cnt, hi2_cnt, all error flags and the registered PWM_synch; holds meas_vld at 0.
REQ-033 After RST_n rises, the first window opens only on a fresh synch_edge after ARM; a PWM_synch already high at release SHALL NOT count as an edge.

Verification (defaults: NCH=2, PER_W=11, NONOVERLAP=32, TOL=4)
REQ-034 duty=1024 on both channels, ideal pair waveforms, synch every 2048 cycles -> meas_vld each period, hi1=hi2=992, no errors.
REQ-035 duty=16 on ch0, PWM1 never high -> exp1 saturates to 0, hi1=0, exp2=2000, no err_duty1[0]; PWM2 high 2010 cycles -> err_duty2[0]=1, ch1 flags stay 0.
REQ-036 One-cycle overlap on ch1 mid-window -> err_ovlp[1]=1 the next cycle, err_ovlp[0]=0; clr_err in the same cycle as a new overlap -> flag stays 1.
REQ-037 Synch after 1000 cycles -> err_synch=1, no meas_vld; synch then absent for 2052 cycles -> state ARM.
REQ-038 RST_n low mid-window, and separately en low mid-window -> no meas_vld; after reset all outputs are 0; the next full window after a fresh synch_edge measures correctly.
REQ-039 hi1 off by exactly 4 cycles passes; off by 5 cycles sets err_duty1.
